// File: rtl/float_sqrt_core.sv
// float_sqrt_core
//   Single-precision (binary32) square root, start/done handshake, fixed
//   28-cycle latency from the start cycle to the done pulse for every operand.
//   Restoring digit recurrence, one result bit per cycle (24 + guard), then
//   round-to-nearest-even using guard and a sticky bit from the remainder.
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      request pulse, op sampled in the same cycle (ignored when busy)
//   op         operand
//   busy       operation in flight (UNPACK..DONE)
//   done       one-cycle pulse, res/underflow/exception valid
//   res        result, held until the next done
//   overflow   constant 0
//   underflow  subnormal operand flushed to signed zero
//   exception  invalid operation, NaN result
module float_sqrt_core #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] op,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] res,
   output logic              overflow,
   output logic              underflow,
   output logic              exception
);

   typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_t;

   state_t      state, nxt;
   logic [31:0] op_q;
   logic [4:0]  cnt;
   logic [49:0] rad;      // radicand bit pairs, consumed from the top
   logic [27:0] rem;      // partial remainder
   logic [24:0] q;        // root bits, q[0] is the guard bit
   logic [7:0]  exp_q;    // result exponent minus one (hidden bit adds it back)
   logic        spec, spec_exc, spec_unf;
   logic [31:0] spec_res;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // ---------------- next state ----------------
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = UNPACK;
         UNPACK:  nxt = ITER;
         ITER:    if (cnt == 5'd24) nxt = ROUND;
         ROUND:   nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      busy     = (state != IDLE);
      done     = (state == DONE);
      overflow = 1'b0;
   end

   // ---------------- unpack ----------------
   // Biased result exponent is floor((E+127)/2); the low bit of E+127 is the
   // parity of the unbiased exponent, i.e. whether the radicand doubles.
   logic [7:0]  u_e;
   logic [22:0] u_m;
   logic [8:0]  u_sum;
   logic [24:0] u_rad;
   assign u_e   = op_q[30:23];
   assign u_m   = op_q[22:0];
   assign u_sum = {1'b0, u_e} + 9'd127;
   assign u_rad = u_sum[0] ? {1'b1, u_m, 1'b0} : {1'b0, 1'b1, u_m};

   // ---------------- recurrence step ----------------
   logic [27:0] it_rem_t, it_trial, it_diff;
   logic        it_ge;
   assign it_rem_t = {rem[25:0], rad[49:48]};
   assign it_trial = {1'b0, q, 2'b01};
   assign it_ge    = (it_rem_t >= it_trial);
   assign it_diff  = it_rem_t - it_trial;

   // ---------------- rounding ----------------
   // Adding the 24-bit significand (hidden bit included) onto exponent-1
   // restores the exponent; a rounding carry-out ripples into the exponent,
   // which is exactly the renormalisation.
   logic        rn_sticky, rn_inc;
   logic [31:0] rn_res;
   assign rn_sticky = |rem;
   assign rn_inc    = q[0] & (rn_sticky | q[1]);
   assign rn_res    = {1'b0, exp_q, 23'd0} + {8'd0, q[24:1]} + {31'd0, rn_inc};

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q      <= '0;
         cnt       <= '0;
         rad       <= '0;
         rem       <= '0;
         q         <= '0;
         exp_q     <= '0;
         spec      <= 1'b0;
         spec_exc  <= 1'b0;
         spec_unf  <= 1'b0;
         spec_res  <= '0;
         res       <= '0;
         underflow <= 1'b0;
         exception <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) op_q <= op;
            UNPACK: begin
               cnt   <= '0;
               rem   <= '0;
               q     <= '0;
               rad   <= {u_rad, 25'd0};
               exp_q <= u_sum[8:1] - 8'd1;
               spec_exc <= 1'b0;
               spec_unf <= 1'b0;
               spec_res <= '0;
               spec     <= 1'b1;
               if (u_e == 8'hFF && u_m != '0) begin
                  spec_res <= 32'h7FC00000;
                  spec_exc <= 1'b1;
               end else if (u_e == 8'h00 && u_m == '0) begin
                  spec_res <= op_q;
               end else if (u_e == 8'h00) begin
                  // subnormal checked before sign: flushes to signed zero
                  spec_res <= {op_q[31], 31'd0};
                  spec_unf <= 1'b1;
               end else if (op_q[31]) begin
                  spec_res <= 32'h7FC00000;
                  spec_exc <= 1'b1;
               end else if (u_e == 8'hFF) begin
                  spec_res <= 32'h7F800000;
               end else begin
                  spec <= 1'b0;
               end
            end
            ITER: begin
               rem <= it_ge ? it_diff : it_rem_t;
               q   <= {q[23:0], it_ge};
               rad <= {rad[47:0], 2'b00};
               cnt <= cnt + 5'd1;
            end
            ROUND: begin
               res       <= spec ? spec_res : rn_res;
               exception <= spec_exc;
               underflow <= spec_unf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float_sqrt_core.sv
module tb_float_sqrt_core;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] op;
   logic        busy, done, overflow, underflow, exception;
   logic [31:0] res;

   float_sqrt_core #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .busy(busy), .done(done), .res(res),
      .overflow(overflow), .underflow(underflow), .exception(exception)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] r;
      logic        x;
      logic        u;
      int unsigned c;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // monitor: pops the scoreboard whenever the DUT signals done
   always @(negedge clk) begin : mon
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = sb.pop_front();
            check("res", res, e.r);
            check("exception", 32'(exception), 32'(e.x));
            check("underflow", 32'(underflow), 32'(e.u));
            check("overflow", 32'(overflow), 32'd0);
            check("done_cycle", cyc, e.c);
         end
      end
   end

   // called at a negedge; start is sampled at the next rising edge
   task automatic issue(input logic [31:0] o, input bit push,
                        input logic [31:0] r, input logic x, input logic u);
      exp_t e;
      start = 1'b1;
      op    = o;
      if (push) begin
         e = '{r: r, x: x, u: u, c: cyc + 28};
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      op    = $urandom;
   endtask

   task automatic wait_to(input int unsigned t);
      while (cyc < t) @(negedge clk);
   endtask

   // independent reference: double-precision sqrt, then RNE to binary32
   function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
      logic [63:0] b;
      logic [10:0] t;
      logic        inc;
      real         v, s;
      t = 11'(x[30:23]) + 11'd896;
      b = {1'b0, t, x[22:0], 29'd0};
      v = $bitstoreal(b);
      s = $sqrt(v);
      b = $realtobits(s);
      t = b[62:52] - 11'd896;
      inc = b[28] & ((|b[27:0]) | b[29]);
      return {1'b0, t[7:0], b[51:29]} + 32'(inc);
   endfunction

   typedef struct {
      logic [31:0] o;
      logic [31:0] r;
      logic        x;
      logic        u;
   } vec_t;

   vec_t vecs[$] = '{
      '{32'h40000000, 32'h3FB504F3, 1'b0, 1'b0},   // sqrt 2
      '{32'h3F800000, 32'h3F800000, 1'b0, 1'b0},   // 1.0
      '{32'h3E800000, 32'h3F000000, 1'b0, 1'b0},   // 0.25 -> 0.5
      '{32'h3F000000, 32'h3F3504F3, 1'b0, 1'b0},   // 0.5, odd negative exponent
      '{32'h7F7FFFFF, 32'h5F7FFFFF, 1'b0, 1'b0},   // max normal
      '{32'h00800000, 32'h20000000, 1'b0, 1'b0},   // min normal
      '{32'h7F800000, 32'h7F800000, 1'b0, 1'b0},   // +inf
      '{32'h80000000, 32'h80000000, 1'b0, 1'b0},   // -0
      '{32'h00000000, 32'h00000000, 1'b0, 1'b0},   // +0
      '{32'h00000001, 32'h00000000, 1'b0, 1'b1},   // subnormal flush
      '{32'h7FC00001, 32'h7FC00000, 1'b1, 1'b0},   // NaN
      '{32'hFF800000, 32'h7FC00000, 1'b1, 1'b0},   // -inf
      '{32'hBF800000, 32'h7FC00000, 1'b1, 1'b0}    // -1.0
   };

   initial begin
      int unsigned c0;
      logic [31:0] ro;
      rst = 1'b1; start = 1'b0; op = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res", res, 32'd0);
      check("rst_exception", 32'(exception), 32'd0);
      check("rst_underflow", 32'(underflow), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);

      // 4.0 in the first cycle after reset release, busy window checked
      rst = 1'b0;
      c0 = cyc;
      issue(32'h40800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
      for (int k = 1; k <= 29; k++) begin
         check($sformatf("busy_c%0d", k), 32'(busy), (k <= 28) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      // start while busy and start during done are both ignored
      c0 = cyc;
      issue(32'h40800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
      wait_to(c0 + 5);
      issue(32'h41100000, 1'b0, '0, 1'b0, 1'b0);
      wait_to(c0 + 28);
      issue(32'hBF800000, 1'b0, '0, 1'b0, 1'b0);
      issue(32'h41100000, 1'b1, 32'h40400000, 1'b0, 1'b0);
      wait_to(c0 + 58);

      // directed table
      foreach (vecs[i]) begin
         c0 = cyc;
         issue(vecs[i].o, 1'b1, vecs[i].r, vecs[i].x, vecs[i].u);
         wait_to(c0 + 29);
      end

      // abort by reset at cycle 10, restart right after
      c0 = cyc;
      issue(32'h40800000, 1'b0, '0, 1'b0, 1'b0);
      wait_to(c0 + 10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_res", res, 32'd0);
      check("abort_exception", 32'(exception), 32'd0);
      check("abort_underflow", 32'(underflow), 32'd0);
      check("abort_overflow", 32'(overflow), 32'd0);
      c0 = cyc;
      issue(32'h3E800000, 1'b1, 32'h3F000000, 1'b0, 1'b0);
      wait_to(c0 + 29);

      // random positive normals against the reference model
      for (int n = 0; n < 150; n++) begin
         ro = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
         c0 = cyc;
         issue(ro, 1'b1, ref_sqrt(ro), 1'b0, 1'b0);
         wait_to(c0 + 29);
      end

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL missing_done: got %0d outstanding expected 0", sb.size());
      end
      repeat (40) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
